// File: rtl/counter_sequence_checker_pkg.sv
// Shared definitions for the counter sequence checker.
// Contents:
//   state_e  - checker FSM states (IDLE=0, ACQUIRE=1, LOCKED=2); the bench monitors
//              use the same encodings.
package counter_sequence_checker_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2
    } state_e;

endpackage

// File: rtl/counter_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   inc    in   1  add one (held at all-ones once saturated)
//   clr    in   1  synchronous clear; with inc in the same cycle the result is 1
//   count  out  W  current count
module counter_sequence_checker_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            // The error arriving with the clear is kept, not lost.
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/counter_sequence_checker.sv
// Checks the output of a WIDTH-bit counter: q must advance by exactly +1 (mod 2^WIDTH)
// per clock. Acquires lock after LOCK_CNT consecutive good steps, then flags every
// broken step. Also flags a counter that does not clear within one cycle of its own
// reset. Violations are counted in a saturating ERR_W-bit counter.
// Ports:
//   clk         in   1      clock, all sampling on the rising edge
//   reset       in   1      asynchronous active-low reset of this block
//   q           in   WIDTH  observed counter value
//   dut_reset   in   1      the counter's own active-high reset, observed
//   enable      in   1      1 = checking active, 0 = hold in IDLE
//   clear_err   in   1      synchronous pulse clearing err_count
//   locked      out  1      high while in LOCKED
//   err_pulse   out  1      one-cycle pulse per detected violation
//   wrap_pulse  out  1      one-cycle pulse on a matched all-ones -> 0 step while LOCKED
//   err_count   out  ERR_W  saturating violation count
//   expected    out  WIDTH  previous sample + 1
module counter_sequence_checker
    import counter_sequence_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    input  logic             dut_reset,
    input  logic             enable,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam logic [GoodW-1:0] LockTarget = GoodW'(LOCK_CNT);

    state_e           state;
    logic [WIDTH-1:0] prev;
    logic [GoodW-1:0] good_cnt;
    logic             rst_seen;

    logic [WIDTH-1:0] prev_inc;
    logic             step_ok;
    logic             hold;
    logic             seq_err;
    logic             rst_err;
    logic             err_det;
    logic             wrap_det;

    always_comb begin
        prev_inc = prev + WIDTH'(1);
        step_ok  = (q == prev_inc);
        hold     = dut_reset || !enable;
        // Sequence errors only count once locked and never while the counter is in reset.
        seq_err  = !hold && (state == StLocked) && !step_ok;
        // Counter still non-zero in the second consecutive cycle of its own reset.
        rst_err  = dut_reset && rst_seen && (q != '0);
        err_det  = seq_err || rst_err;
        wrap_det = !hold && (state == StLocked) && step_ok && (prev == '1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            prev       <= '0;
            good_cnt   <= '0;
            rst_seen   <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            expected   <= '0;
        end else begin
            prev       <= q;
            expected   <= q + WIDTH'(1);
            rst_seen   <= dut_reset;
            err_pulse  <= err_det;
            wrap_pulse <= wrap_det;

            if (hold) begin
                state    <= StIdle;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        state    <= StAcquire;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                    StAcquire: begin
                        if (step_ok) begin
                            if ((good_cnt + GoodW'(1)) == LockTarget) begin
                                state    <= StLocked;
                                good_cnt <= '0;
                                locked   <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + GoodW'(1);
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    StLocked: begin
                        if (!step_ok) begin
                            state    <= StAcquire;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Counts on the same edge that raises err_pulse.
    counter_sequence_checker_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_det),
        .clr   (clear_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed bench for counter_sequence_checker. Two instances share all stimulus: the
// default configuration and one with a 2-bit error counter to exercise saturation.
module tb_counter_sequence_checker;

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic       dut_reset;
    logic       enable;
    logic       clear_err;

    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [3:0] expected;

    logic       s_locked;
    logic       s_err_pulse;
    logic       s_wrap_pulse;
    logic [1:0] s_err_count;
    logic [3:0] s_expected;

    int n_cmp = 0;
    int n_err = 0;

    counter_sequence_checker #(
        .WIDTH    (4),
        .LOCK_CNT (2),
        .ERR_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .q          (q),
        .dut_reset  (dut_reset),
        .enable     (enable),
        .clear_err  (clear_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .expected   (expected)
    );

    counter_sequence_checker #(
        .WIDTH    (4),
        .LOCK_CNT (2),
        .ERR_W    (2)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .q          (q),
        .dut_reset  (dut_reset),
        .enable     (enable),
        .clear_err  (clear_err),
        .locked     (s_locked),
        .err_pulse  (s_err_pulse),
        .wrap_pulse (s_wrap_pulse),
        .err_count  (s_err_count),
        .expected   (s_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, clock it in, look at the registered outputs just after the edge.
    task automatic cyc(input logic [3:0] v);
        q = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        q         = 4'd0;
        dut_reset = 1'b1;
        enable    = 1'b0;
        clear_err = 1'b0;
        #1 reset = 1'b0;
        #2;
        check_eq("rst_locked", locked, 0);
        check_eq("rst_err_pulse", err_pulse, 0);
        check_eq("rst_wrap_pulse", wrap_pulse, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_expected", expected, 0);
        check_eq("rst_s_err_count", s_err_count, 0);

        #9;
        reset  = 1'b1;
        enable = 1'b1;

        // Clean run: counter held in reset for two edges, then counts from 0.
        cyc(4'd0);
        cyc(4'd0);
        check_eq("clean_rst_err", err_pulse, 0);
        check_eq("clean_rst_locked", locked, 0);
        dut_reset = 1'b0;
        cyc(4'd0);
        check_eq("acq_locked0", locked, 0);
        cyc(4'd1);
        check_eq("acq_locked1", locked, 0);
        cyc(4'd2);
        check_eq("lock_after_2", locked, 1);
        check_eq("expected_3", expected, 3);
        for (int i = 3; i <= 36; i++) begin
            cyc(4'(i));
            check_eq("run_wrap", wrap_pulse, ((i % 16) == 0) ? 1 : 0);
            check_eq("run_err", err_pulse, 0);
            check_eq("run_locked", locked, 1);
        end
        check_eq("clean_err_count", err_count, 0);

        // Skip: 5 -> 7 while locked.
        cyc(4'd5);
        check_eq("skip_pre_locked", locked, 1);
        cyc(4'd7);
        check_eq("skip_err_pulse", err_pulse, 1);
        check_eq("skip_err_count", err_count, 1);
        check_eq("skip_s_err_count", s_err_count, 1);
        check_eq("skip_locked", locked, 0);
        check_eq("skip_expected", expected, 8);
        cyc(4'd8);
        check_eq("skip_pulse_end", err_pulse, 0);
        check_eq("skip_acq", locked, 0);
        cyc(4'd9);
        check_eq("skip_relock", locked, 1);

        // Stall: q holds 9.
        cyc(4'd9);
        check_eq("stall_err_pulse", err_pulse, 1);
        check_eq("stall_locked", locked, 0);
        check_eq("stall_err_count", err_count, 2);
        cyc(4'd9);
        check_eq("stall_acq_no_err", err_pulse, 0);
        check_eq("stall_acq_count", err_count, 2);
        cyc(4'd10);
        cyc(4'd11);
        check_eq("stall_relock", locked, 1);

        // Counter reset fault: q stays at 4 through three reset cycles.
        dut_reset = 1'b1;
        cyc(4'd4);
        check_eq("rstf_c1_err", err_pulse, 0);
        check_eq("rstf_c1_locked", locked, 0);
        cyc(4'd4);
        check_eq("rstf_c2_err", err_pulse, 1);
        check_eq("rstf_c2_count", err_count, 3);
        cyc(4'd4);
        check_eq("rstf_c3_err", err_pulse, 1);
        check_eq("rstf_c3_count", err_count, 4);
        check_eq("sat_count", s_err_count, 3);
        dut_reset = 1'b0;
        cyc(4'd0);
        check_eq("rstf_done_err", err_pulse, 0);
        check_eq("rstf_done_count", err_count, 4);

        // Counter reset done correctly: q reaches 0 by the second cycle.
        dut_reset = 1'b1;
        cyc(4'd4);
        check_eq("rstok_c1_err", err_pulse, 0);
        cyc(4'd0);
        check_eq("rstok_c2_err", err_pulse, 0);
        cyc(4'd0);
        check_eq("rstok_c3_err", err_pulse, 0);
        check_eq("rstok_count", err_count, 4);
        check_eq("rstok_s_count", s_err_count, 3);
        dut_reset = 1'b0;
        cyc(4'd0);
        cyc(4'd1);
        cyc(4'd2);
        check_eq("rstok_relock", locked, 1);

        // enable=0 while locked, with a broken step: IDLE, no error.
        enable = 1'b0;
        cyc(4'd7);
        check_eq("dis_err", err_pulse, 0);
        check_eq("dis_locked", locked, 0);
        check_eq("dis_count", err_count, 4);
        enable = 1'b1;
        cyc(4'd8);
        check_eq("en_idle_exit", locked, 0);
        cyc(4'd9);
        cyc(4'd10);
        check_eq("en_relock", locked, 1);

        // Clear with a simultaneous error, then clear alone.
        clear_err = 1'b1;
        cyc(4'd12);
        check_eq("clr_err_pulse", err_pulse, 1);
        check_eq("clr_with_err", err_count, 1);
        check_eq("clr_with_err_s", s_err_count, 1);
        cyc(4'd13);
        check_eq("clr_alone", err_count, 0);
        check_eq("clr_alone_s", s_err_count, 0);
        clear_err = 1'b0;
        cyc(4'd14);
        check_eq("clr_relock", locked, 1);
        cyc(4'd0);
        check_eq("post_clr_err", err_pulse, 1);
        check_eq("post_clr_count", err_count, 1);
        cyc(4'd1);
        cyc(4'd2);
        check_eq("pre_async_locked", locked, 1);
        check_eq("pre_async_expected", expected, 3);

        // Asynchronous reset between edges.
        #3 reset = 1'b0;
        #1;
        check_eq("async_locked", locked, 0);
        check_eq("async_expected", expected, 0);
        check_eq("async_count", err_count, 0);
        check_eq("async_s_count", s_err_count, 0);
        check_eq("async_err_pulse", err_pulse, 0);
        #2 reset = 1'b1;
        cyc(4'd0);
        check_eq("after_async_locked", locked, 0);
        cyc(4'd1);
        cyc(4'd2);
        check_eq("after_async_relock", locked, 1);
        check_eq("after_async_count", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
